regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with an integrated write-pending scoreboard, for the dual-issue core pipeline. It provides NREAD combinational read ports and NWRITE synchronous write ports with same-cycle write-to-read bypass. A per-register pending bit is set at issue and cleared at writeback, so the decode stage can detect RAW hazards (`rbusy`) and WAW hazards (`iss_ready`) without a separate scoreboard block. Register 0 is hardwired to zero and is never pending.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, address width; depth = 2**ADDR_W
- `NREAD`, 2, read ports (≥1)
- `NWRITE`, 2, write ports (≥1); a higher index means higher priority
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `we`  in  NWRITE  per-port write enable
- `waddr`  in  NWRITE*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
- `wdata`  in  NWRITE*DATA_W  write data, packed the same way
- `re`  in  NREAD  per-port read enable
- `raddr`  in  NREAD*ADDR_W  read addresses, packed
- `rdata`  out  NREAD*DATA_W  read data, packed, combinational
- `rbusy`  out  NREAD  read target still pending after this cycle's writes
- `iss_valid`  in  1  issue request: mark `iss_addr` pending
- `iss_addr`  in  ADDR_W  destination of the issuing instruction
- `iss_ready`  out  1  issue accepted this cycle (no WAW conflict)

## Operation
- Storage: 2**ADDR_W × DATA_W registers, plus one pending bit per register.
- Write: on a rising edge with `rst` low, each port with `we`=1 and `waddr`≠0 writes its `wdata`. If several ports target the same address, only the highest-index port's data lands.
- Write clears pending: any enabled write to address a (a≠0) clears pending[a] at the same edge.
- Issue: `iss_ready` = !rst && (iss_addr==0 || !pending_eff[iss_addr]). pending_eff[a] is pending[a] AND NOT (a is written this cycle). On an edge with `iss_valid && iss_ready && iss_addr≠0`, pending[iss_addr] is set. Set wins over clear for the same address in the same cycle.
- `iss_valid` with `iss_ready`=0 has no effect. The requester holds the request and retries.
- Read port j, in priority order:
  - rst=1 → 0
  - raddr=0 → 0
  - re=0 → 0
  - address matches any enabled write port → data of the highest-index matching write port (bypass)
  - otherwise → stored value
- `rbusy[j]` = re[j] && raddr≠0 && pending_eff[raddr]. A bypassed read is not busy.

## Timing
- Reads, `rbusy` and `iss_ready` are purely combinational: zero-cycle latency.
- Write data is visible through the array from the cycle after the edge. It is visible through the bypass in the same cycle.
- Reset, asserted at any time: all registers are 0 and all pending bits are 0 immediately, without waiting for a clock edge. While `rst` is high, `rdata` is 0, `rbusy` is 0 and `iss_ready` is 0. Writes and issues are ignored. The first edge after deassertion is a normal cycle.
- Simultaneous write to a and issue to a: the result is that a is pending and holds the new data.
- Writes to address 0 and issues to address 0 are silently dropped. Reading address 0 always returns 0 and is never busy.

## Structure
- The shared define header provides `RstEnable`, `WriteEnable`, `ReadEnable` and `ZeroWord`. This block uses those definitions rather than local literals.
- Sub-module `regfile_scoreboard`:
  - Holds the pending vector.
  - Inputs: issue, write-clear, `rst`.
  - Outputs: pending_eff and `iss_ready`.
- `regfile_mp` holds the data array, write-priority resolution and the read/bypass muxes.

## Test plan
- Reset mid-run: write 0xDEADBEEF to r5, then pulse `rst` between edges → r5 reads 0 immediately and `rbusy`=0. After release, r5 still reads 0.
- Write conflict, NWRITE=2: port0 writes r3=0x11 and port1 writes r3=0x22 in the same cycle → bypass returns 0x22 that cycle, and the array holds 0x22 on the next cycle.
- Bypass: port1 writes r7=0xA5A5A5A5 while read port 0 reads r7 in the same cycle → rdata0=0xA5A5A5A5. Repeat with re0=0 → rdata0=0.
- Scoreboard RAW: issue r9 → next cycle reading r9 gives rbusy=1. When port0 writes r9=0x5 → rbusy=0 and rdata=0x5 that same cycle.
- Scoreboard WAW: r4 pending and iss_addr=r4 → iss_ready=0, pending unchanged. In the cycle r4 is written, the same issue gives iss_ready=1 and r4 remains pending.
- r0 rules: write r0=0xFFFFFFFF and issue r0 → r0 reads 0, rbusy=0, iss_ready=1, and no pending bit is ever set.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: enable polarities and the zero word.
package regfile_mp_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        ReadEnable  = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register write-pending scoreboard: set at issue, cleared at writeback.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    localparam int unsigned DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [DEPTH-1:0]  wclr,
    output logic [DEPTH-1:0]  pending_eff,
    output logic              iss_ready
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // A write landing this cycle already resolves the hazard on its address.
    assign pending_eff = pending_q & ~wclr;

    always_comb begin
        iss_ready = 1'b0;
        if (rst != RstEnable) begin
            iss_ready = (iss_addr == '0) || !pending_eff[iss_addr];
        end
    end

    // Set is applied after clear so an issue wins over a same-cycle writeback.
    always_comb begin
        pending_d = pending_eff;
        if (iss_valid && iss_ready && (iss_addr != '0)) begin
            pending_d[iss_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, same-cycle bypass and an integrated scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] waddr,
    input  logic [NWRITE*DATA_W-1:0] wdata,
    input  logic [NREAD-1:0]         re,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    output logic [NREAD-1:0]         rbusy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] Zero = DATA_W'(ZeroWord);

    logic [ADDR_W-1:0] wa [NWRITE];
    logic [DATA_W-1:0] wd [NWRITE];
    logic [ADDR_W-1:0] ra [NREAD];
    logic [DATA_W-1:0] rd [NREAD];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [DEPTH-1:0] wclr;
    logic [DEPTH-1:0] pending_eff;

    for (genvar k = 0; k < NWRITE; k++) begin : g_wport
        assign wa[k] = waddr[k*ADDR_W +: ADDR_W];
        assign wd[k] = wdata[k*DATA_W +: DATA_W];
    end

    for (genvar j = 0; j < NREAD; j++) begin : g_rport
        assign ra[j]                   = raddr[j*ADDR_W +: ADDR_W];
        assign rdata[j*DATA_W +: DATA_W] = rd[j];
    end

    always_comb begin
        wclr = '0;
        for (int k = 0; k < NWRITE; k++) begin
            if ((we[k] == WriteEnable) && (wa[k] != '0)) begin
                wclr[wa[k]] = 1'b1;
            end
        end
    end

    // Ascending port order: the highest-index writer to an address lands last.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NWRITE; k++) begin
            if ((we[k] == WriteEnable) && (wa[k] != '0)) begin
                mem_d[wa[k]] = wd[k];
            end
        end
        mem_d[0] = Zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= Zero;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        for (int j = 0; j < NREAD; j++) begin
            rd[j] = Zero;
            if ((rst != RstEnable) && (ra[j] != '0) && (re[j] == ReadEnable)) begin
                rd[j] = mem_q[ra[j]];
                for (int k = 0; k < NWRITE; k++) begin
                    if ((we[k] == WriteEnable) && (wa[k] == ra[j])) begin
                        rd[j] = wd[k];
                    end
                end
            end
        end
    end

    always_comb begin
        rbusy = '0;
        for (int j = 0; j < NREAD; j++) begin
            rbusy[j] = (rst != RstEnable) && (re[j] == ReadEnable) && (ra[j] != '0)
                       && pending_eff[ra[j]];
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_addr    (iss_addr),
        .wclr        (wclr),
        .pending_eff (pending_eff),
        .iss_ready   (iss_ready)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DATA_W=32, ADDR_W=5, NREAD=2, NWRITE=2).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;

    int total = 0;
    int bad   = 0;

    regfile_mp #(
        .DATA_W (32),
        .ADDR_W (5),
        .NREAD  (2),
        .NWRITE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready)
    );

    always #5 clk = ~clk;

    task automatic idle();
        we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        re = 2'b11; raddr = {5'd2, 5'd1};
        #1;
        total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL reset_iss_ready got=%b exp=0", iss_ready); end
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        // Write r5 and issue r6 so both storage and pending state are non-zero.
        we[0] = 1'b1; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
        iss_valid = 1'b1; iss_addr = 5'd6;
        @(negedge clk);
        idle();
        re = 2'b11; raddr = {5'd6, 5'd5};
        #1;
        total++; if (rdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_rst_r5 got=%h exp=deadbeef", rdata[31:0]); end
        total++; if (rbusy[1] !== 1'b1) begin bad++; $display("FAIL pre_rst_r6_busy got=%b exp=1", rbusy[1]); end
        #1 rst = 1'b1;
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL rst_r5 got=%h exp=0", rdata[31:0]); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL rst_rbusy got=%b exp=00", rbusy); end
        #1 rst = 1'b0;
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL post_rst_r5 got=%h exp=0", rdata[31:0]); end
        total++; if (rbusy[1] !== 1'b0) begin bad++; $display("FAIL post_rst_r6_busy got=%b exp=0", rbusy[1]); end
        @(negedge clk);
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL post_rst_r5_edge got=%h exp=0", rdata[31:0]); end
    endtask

    task automatic test_write_conflict();
        @(negedge clk);
        idle();
        we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11};
        re[0] = 1'b1; raddr[4:0] = 5'd3;
        #1;
        total++; if (rdata[31:0] !== 32'h22) begin bad++; $display("FAIL conflict_bypass got=%h exp=22", rdata[31:0]); end
        @(negedge clk);
        we = 2'b00;
        #1;
        total++; if (rdata[31:0] !== 32'h22) begin bad++; $display("FAIL conflict_array got=%h exp=22", rdata[31:0]); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        we[1] = 1'b1; waddr[9:5] = 5'd7; wdata[63:32] = 32'hA5A5A5A5;
        re[0] = 1'b1; raddr[4:0] = 5'd7;
        #1;
        total++; if (rdata[31:0] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_rd0 got=%h exp=a5a5a5a5", rdata[31:0]); end
        re[0] = 1'b0;
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL bypass_re0_off got=%h exp=0", rdata[31:0]); end
        @(negedge clk);
        idle();
        re[1] = 1'b1; raddr[9:5] = 5'd7;
        #1;
        total++; if (rdata[63:32] !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_array_rd1 got=%h exp=a5a5a5a5", rdata[63:32]); end
    endtask

    task automatic test_raw();
        @(negedge clk);
        idle();
        iss_valid = 1'b1; iss_addr = 5'd9;
        #1;
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL raw_issue_ready got=%b exp=1", iss_ready); end
        @(negedge clk);
        idle();
        re[0] = 1'b1; raddr[4:0] = 5'd9;
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL raw_busy got=%b exp=1", rbusy[0]); end
        we[0] = 1'b1; waddr[4:0] = 5'd9; wdata[31:0] = 32'h5;
        #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL raw_wb_busy got=%b exp=0", rbusy[0]); end
        total++; if (rdata[31:0] !== 32'h5) begin bad++; $display("FAIL raw_wb_data got=%h exp=5", rdata[31:0]); end
        @(negedge clk);
        we = '0;
        #1;
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL raw_cleared got=%b exp=0", rbusy[0]); end
    endtask

    task automatic test_waw();
        @(negedge clk);
        idle();
        iss_valid = 1'b1; iss_addr = 5'd4;
        @(negedge clk);
        re[0] = 1'b1; raddr[4:0] = 5'd4;
        #1;
        total++; if (iss_ready !== 1'b0) begin bad++; $display("FAIL waw_blocked got=%b exp=0", iss_ready); end
        @(negedge clk);
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL waw_still_pending got=%b exp=1", rbusy[0]); end
        we[1] = 1'b1; waddr[9:5] = 5'd4; wdata[63:32] = 32'h44;
        #1;
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL waw_wb_ready got=%b exp=1", iss_ready); end
        total++; if (rbusy[0] !== 1'b0) begin bad++; $display("FAIL waw_wb_busy got=%b exp=0", rbusy[0]); end
        @(negedge clk);
        idle();
        re[0] = 1'b1; raddr[4:0] = 5'd4;
        #1;
        total++; if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL waw_set_wins got=%b exp=1", rbusy[0]); end
        total++; if (rdata[31:0] !== 32'h44) begin bad++; $display("FAIL waw_new_data got=%h exp=44", rdata[31:0]); end
        // Retire r4 so later tests start clean.
        we[0] = 1'b1; waddr[4:0] = 5'd4; wdata[31:0] = 32'h44;
        @(negedge clk);
        idle();
    endtask

    task automatic test_r0();
        @(negedge clk);
        idle();
        we[0] = 1'b1; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_addr = 5'd0;
        re = 2'b11; raddr = '0;
        #1;
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL r0_rdata got=%h exp=0", rdata); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL r0_rbusy got=%b exp=00", rbusy); end
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL r0_iss_ready got=%b exp=1", iss_ready); end
        @(negedge clk);
        we = '0;
        #1;
        total++; if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL r0_after got=%h exp=0", rdata[31:0]); end
        total++; if (rbusy !== 2'b00) begin bad++; $display("FAIL r0_busy_after got=%b exp=00", rbusy); end
        total++; if (iss_ready !== 1'b1) begin bad++; $display("FAIL r0_ready_after got=%b exp=1", iss_ready); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle();
        we[0] = 1'b1; waddr[4:0] = 5'd10; wdata[31:0] = 32'h1;
        @(negedge clk);
        idle();
        we[1] = 1'b1; waddr[9:5] = 5'd11; wdata[63:32] = 32'h2;
        re = 2'b11; raddr = {5'd11, 5'd10};
        #1;
        total++; if (rdata !== {32'h2, 32'h1}) begin bad++; $display("FAIL b2b_mixed got=%h exp=0000000200000001", rdata); end
        @(negedge clk);
        we = '0;
        #1;
        total++; if (rdata !== {32'h2, 32'h1}) begin bad++; $display("FAIL b2b_array got=%h exp=0000000200000001", rdata); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_write_conflict();
        test_bypass();
        test_raw();
        test_waw();
        test_r0();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
